sound_fx_sequencer: RTL

- Consumer of the one-cycle sound time-base tick (`Z` of the sound time counter); produces the speaker square wave for three game sound effects.
- Effects: shot (rising-period sweep), explosion ("boom"), invader march step.
- Drives the time counter's `EN` through `tick_en`, so the time base runs only while a sound plays.

---
 rtl/sound_pkg.sv | 35 +++
 rtl/tone_divider.sv | 46 ++++
 rtl/sound_fx_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared definitions for the sound effect sequencer: state codes, default
// timing constants, effect priority and the noise LFSR seed/taps.
package sound_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOT  = 2'd1,
        ST_BOOM  = 2'd2,
        ST_MARCH = 2'd3
    } fx_state_e;

    localparam int unsigned HALF_W_DEF     = 8;
    localparam int unsigned DUR_W_DEF      = 10;
    localparam int unsigned SHOT_HALF_DEF  = 20;
    localparam int unsigned SHOT_DUR_DEF   = 600;
    localparam int unsigned BOOM_HALF_DEF  = 60;
    localparam int unsigned BOOM_DUR_DEF   = 900;
    localparam int unsigned MARCH_HALF_DEF = 120;
    localparam int unsigned MARCH_DUR_DEF  = 240;

    // Fibonacci taps 8,6,5,4 as a mask over bits [7:0]
    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Higher value wins; IDLE ranks below every effect
    function automatic logic [1:0] fx_prio(input fx_state_e s);
        case (s)
            ST_BOOM:  fx_prio = 2'd3;
            ST_SHOT:  fx_prio = 2'd2;
            ST_MARCH: fx_prio = 2'd1;
            default:  fx_prio = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period divider: counts qualified ticks against cur_half and strobes
// toggle_c at the end of each half period; optionally sweeps cur_half upward.
module tone_divider
    import sound_pkg::*;
#(
    parameter int unsigned HALF_W = HALF_W_DEF
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              load,
    input  logic [HALF_W-1:0] load_half,
    input  logic              clear,
    input  logic              advance,
    input  logic              sweep,
    output logic              toggle_c
);

    logic [HALF_W-1:0] hp_cnt;
    logic [HALF_W-1:0] cur_half;

    assign toggle_c = advance && (hp_cnt == cur_half - HALF_W'(1));

    // load beats clear beats advance; sweep saturates at all-ones
    always_ff @(posedge CLK) begin
        if (!Rst) begin
            hp_cnt   <= '0;
            cur_half <= '0;
        end else if (load) begin
            hp_cnt   <= '0;
            cur_half <= load_half;
        end else if (clear) begin
            hp_cnt   <= '0;
            cur_half <= '0;
        end else if (advance) begin
            if (toggle_c) begin
                hp_cnt <= '0;
                if (sweep && (cur_half != '1)) begin
                    cur_half <= cur_half + HALF_W'(1);
                end
            end else begin
                hp_cnt <= hp_cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/sound_fx_sequencer.sv
// Sound effect sequencer: shot sweep, boom and march square waves driven by the
// sound time-base tick. Define SOUND_NOISE_EN for an LFSR-noise explosion.
module sound_fx_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned HALF_W     = HALF_W_DEF,
    parameter int unsigned DUR_W      = DUR_W_DEF,
    parameter int unsigned SHOT_HALF  = SHOT_HALF_DEF,
    parameter int unsigned SHOT_DUR   = SHOT_DUR_DEF,
    parameter int unsigned BOOM_HALF  = BOOM_HALF_DEF,
    parameter int unsigned BOOM_DUR   = BOOM_DUR_DEF,
    parameter int unsigned MARCH_HALF = MARCH_HALF_DEF,
    parameter int unsigned MARCH_DUR  = MARCH_DUR_DEF
) (
    input  logic       CLK,
    input  logic       Rst,
    input  logic       tick,
    input  logic       trig_shot,
    input  logic       trig_boom,
    input  logic       trig_march,
    output logic       spk,
    output logic       busy,
    output logic       tick_en,
    output logic [1:0] effect
);

    // Truncate to the counter width and promote zero to one
    function automatic logic [HALF_W-1:0] half_eff(input int unsigned v);
        half_eff = (HALF_W'(v) == '0) ? HALF_W'(1) : HALF_W'(v);
    endfunction

    function automatic logic [DUR_W-1:0] dur_eff(input int unsigned v);
        dur_eff = (DUR_W'(v) == '0) ? DUR_W'(1) : DUR_W'(v);
    endfunction

    localparam logic [HALF_W-1:0] SHOT_H  = half_eff(SHOT_HALF);
    localparam logic [HALF_W-1:0] BOOM_H  = half_eff(BOOM_HALF);
    localparam logic [HALF_W-1:0] MARCH_H = half_eff(MARCH_HALF);
    localparam logic [DUR_W-1:0]  SHOT_D  = dur_eff(SHOT_DUR);
    localparam logic [DUR_W-1:0]  BOOM_D  = dur_eff(BOOM_DUR);
    localparam logic [DUR_W-1:0]  MARCH_D = dur_eff(MARCH_DUR);

    fx_state_e         state_q, state_d, req;
    logic [DUR_W-1:0]  dur_q, dur_d, dur_lim;
    logic [HALF_W-1:0] req_half;
    logic              spk_q, spk_d, busy_q, busy_d;
    logic              accept, fx_tick, ending, toggle_c;
`ifdef SOUND_NOISE_EN
    logic [7:0]        lfsr_q, lfsr_d;
`endif

    always_ff @(posedge CLK) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            dur_q   <= '0;
            spk_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SOUND_NOISE_EN
            lfsr_q  <= LFSR_SEED;
`endif
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            spk_q   <= spk_d;
            busy_q  <= busy_d;
`ifdef SOUND_NOISE_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    // Trigger arbitration, duration counting and speaker level
    always_comb begin
        state_d  = state_q;
        dur_d    = dur_q;
        spk_d    = spk_q;
        busy_d   = busy_q;
        req      = ST_IDLE;
        req_half = '0;
        dur_lim  = DUR_W'(1);
`ifdef SOUND_NOISE_EN
        lfsr_d   = lfsr_q;
`endif

        if (trig_boom) begin
            req = ST_BOOM;
        end else if (trig_shot) begin
            req = ST_SHOT;
        end else if (trig_march) begin
            req = ST_MARCH;
        end

        case (req)
            ST_SHOT:  req_half = SHOT_H;
            ST_BOOM:  req_half = BOOM_H;
            ST_MARCH: req_half = MARCH_H;
            default:  req_half = '0;
        endcase

        case (state_q)
            ST_SHOT:  dur_lim = SHOT_D;
            ST_BOOM:  dur_lim = BOOM_D;
            ST_MARCH: dur_lim = MARCH_D;
            default:  dur_lim = DUR_W'(1);
        endcase

        // An accepted trigger swallows a coincident tick
        accept  = (req != ST_IDLE) && (fx_prio(req) >= fx_prio(state_q));
        fx_tick = tick && (state_q != ST_IDLE) && !accept;
        ending  = fx_tick && (dur_q == dur_lim - DUR_W'(1));

        if (accept) begin
            state_d = req;
            dur_d   = '0;
            spk_d   = 1'b0;
            busy_d  = 1'b1;
        end else if (ending) begin
            state_d = ST_IDLE;
            dur_d   = '0;
            spk_d   = 1'b0;
            busy_d  = 1'b0;
        end else if (fx_tick) begin
            dur_d = dur_q + DUR_W'(1);
            if (toggle_c) begin
`ifdef SOUND_NOISE_EN
                if (state_q == ST_BOOM) begin
                    spk_d  = lfsr_q[0];
                    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
                end else begin
                    spk_d = ~spk_q;
                end
`else
                spk_d = ~spk_q;
`endif
            end
        end
    end

    tone_divider #(
        .HALF_W (HALF_W)
    ) u_tone (
        .CLK       (CLK),
        .Rst       (Rst),
        .load      (accept),
        .load_half (req_half),
        .clear     (ending),
        .advance   (fx_tick),
        .sweep     (state_q == ST_SHOT),
        .toggle_c  (toggle_c)
    );

    assign spk     = spk_q;
    assign busy    = busy_q;
    assign tick_en = busy_q;
    assign effect  = state_q;

endmodule
